mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/wait_timer.sv | 39 +++
 rtl/mem_access_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the data-memory access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ABORT  = 2'd3
    } state_t;

    // Command captured in IDLE and held for the whole access.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/wait_timer.sv
// Wait-cycle counter with synchronous clear, count enable and terminal count.
// Latency: tc_o is combinational from the registered count.
// Backpressure: none; the owner stops enabling at terminal count, so it never wraps.
module wait_timer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: latches a load/store and waits for mem_ready_i.
// Latency: N+2 stall cycles for a ready after N wait cycles; aborts after TIMEOUT ACCESS cycles.
// Backpressure: stall_o freezes the upstream pipeline while a command is pending or in ACCESS.
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        stall_o,
    output logic        wb_bubble_o,
    output logic [31:0] data_o,
    output logic        timeout_o,
    output logic        err_o
);

    state_t      state_q, state_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        cnt_clr, cnt_en, cnt_tc;
    logic        cmd_vld;

    assign cmd_vld = MemRead_i | MemWrite_i;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_vld) begin
                    state_d = ST_ACCESS;
                    // A simultaneous read+write request is issued as a write.
                    cmd_d   = '{we: MemWrite_i, addr: addr_i, wdata: wdata_i};
                    cnt_clr = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Ready wins over a timeout landing in the same cycle.
                if (mem_ready_i) begin
                    state_d = ST_DONE;
                    if (!cmd_q.we) begin
                        data_d = mem_rdata_i;
                    end
                end else if (cnt_tc) begin
                    state_d = ST_ABORT;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign mem_req_o   = (state_q == ST_ACCESS);
    assign mem_we_o    = (state_q == ST_ACCESS) & cmd_q.we;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;
    assign stall_o     = ((state_q == ST_IDLE) & cmd_vld) | (state_q == ST_ACCESS);
    assign wb_bubble_o = stall_o;
    assign data_o      = data_q;
    assign timeout_o   = (state_q == ST_ABORT);
    assign err_o       = err_q;

endmodule
